// File: rtl/fetch_queue.sv
// Instruction-fetch front end: drives the instruction memory address every cycle and buffers
// returned words with their PC in a small FIFO. The FIFO feeds the instruction register
// through a valid/ready handshake. A redirect flushes buffered and in-flight words and
// restarts fetch at a new PC.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [63:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic            issued_q, issued_d;
  logic            kill_q, kill_d;
  logic [63:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     mem_pc_q [DEPTH];
  logic [63:0]     mem_pc_d [DEPTH];
  logic [31:0]     mem_word_q [DEPTH];
  logic [31:0]     mem_word_d [DEPTH];
  logic [63:0]     hold_pc_q, hold_pc_d;
  logic [31:0]     hold_word_q, hold_word_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CntW:0]   credit;

  // Outputs: head entry when present, otherwise the last value shown.
  always_comb begin
    instr_valid = (count_q != '0);
    instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : hold_pc_q;
    instr       = instr_valid ? mem_word_q[rd_ptr_q] : hold_word_q;
    imem_addr   = fetch_pc_q[31:0];
    count       = count_q;
  end

  // Handshake and credit accounting: an issue is allowed only if its word will have a slot.
  always_comb begin
    pop    = instr_valid & instr_ready & ~redirect;
    push   = issued_q & ~kill_q & ~redirect;
    credit = {1'b0, count_q} + (CntW + 1)'(issued_q) - (CntW + 1)'(pop);
    issue  = (credit < (CntW + 1)'(DEPTH)) & ~redirect;
  end

  // Next-state logic; redirect overrides issue, push and pop.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_d    = 1'b0;
    // Redirect already clears issued_q, so no stale response can reach the FIFO.
    kill_d      = 1'b0;
    req_pc_d    = req_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_pc_d    = mem_pc_q;
    mem_word_d  = mem_word_q;
    hold_pc_d   = instr_pc;
    hold_word_d = instr;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 64'd4;
        issued_d   = 1'b1;
      end
      if (push) begin
        mem_pc_d[wr_ptr_q]   = req_pc_q;
        mem_word_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      issued_q    <= 1'b0;
      kill_q      <= 1'b0;
      req_pc_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hold_pc_q   <= '0;
      hold_word_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_q    <= issued_d;
      kill_q      <= kill_d;
      req_pc_q    <= req_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      hold_pc_q   <= hold_pc_d;
      hold_word_q <= hold_word_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    mem_pc_q   <= mem_pc_d;
    mem_word_q <= mem_word_d;
  end

endmodule
